// File: rtl/dma_desc_pkg.sv
// rtl/dma_desc_pkg.sv - shared types and register map for the DMA descriptor loader
package dma_desc_pkg;

   localparam int DESC_DATA_W = 32;

   localparam int unsigned REG_CTRL = 0;
   localparam int unsigned REG_SRC  = 1;
   localparam int unsigned REG_DST  = 2;
   localparam int unsigned REG_LEN  = 3;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_ENABLE_BIT = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_CTRL,
      ST_CHK,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [DESC_DATA_W-1:0] src;
      logic [DESC_DATA_W-1:0] dst;
      logic [DESC_DATA_W-1:0] len;
   } desc_t;

   // Register read during each issue cycle of the fetch sequence.
   function automatic int unsigned fetch_offset(input logic [1:0] cnt);
      case (cnt)
         2'd0:    return REG_SRC;
         2'd1:    return REG_DST;
         default: return REG_LEN;
      endcase
   endfunction

endpackage

// File: rtl/dma_poll_timer.sv
// rtl/dma_poll_timer.sv - loadable down-counter pacing control-register polls
module dma_poll_timer #(
   parameter int unsigned INTERVAL = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam int unsigned CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(INTERVAL - 1);

   logic [CW-1:0] count;

   // Reset counts as an IDLE entry, so the first poll waits a full interval.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= LOAD_VAL;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (en && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/dma_desc_loader.sv
// rtl/dma_desc_loader.sv - polls CTRL, fetches and validates one descriptor; DMA_DESC_ALIGN_CHECK_EN adds alignment rejection
module dma_desc_loader #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 8,
   parameter int POLL_INTERVAL = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  rf_rd_en,
   output logic [ADDR_WIDTH-1:0] rf_rd_addr,
   input  logic [DATA_WIDTH-1:0] rf_rd_data,
   output logic                  desc_valid,
   input  logic                  desc_ready,
   output logic [DATA_WIDTH-1:0] desc_src,
   output logic [DATA_WIDTH-1:0] desc_dst,
   output logic [DATA_WIDTH-1:0] desc_len,
   input  logic                  eng_done,
   output logic                  busy,
   output logic                  done_pulse,
   output logic                  err
);

   import dma_desc_pkg::*;

   state_t     state;
   state_t     next_state;
   logic [1:0] fetch_cnt;
   logic       start_prev;
   logic       err_q;
   desc_t      desc_q;
   logic       poll_tc;
   logic       poll_load;
   logic       ctrl_fire;
   logic       desc_bad;

   dma_poll_timer #(
      .INTERVAL (POLL_INTERVAL)
   ) u_poll_timer (
      .clk   (clk),
      .reset (reset),
      .load  (poll_load),
      .en    (state == ST_IDLE),
      .tc    (poll_tc)
   );

   assign poll_load = (state != ST_IDLE) && (next_state == ST_IDLE);

   // A start fires only on a 0->1 transition seen across two CTRL polls.
   assign ctrl_fire = rf_rd_data[CTRL_START_BIT] && !start_prev &&
                      rf_rd_data[CTRL_ENABLE_BIT];

   // LEN is still on rf_rd_data in the last fetch cycle; SRC/DST are already captured.
   always_comb begin
      desc_bad = (rf_rd_data == '0);
`ifdef DMA_DESC_ALIGN_CHECK_EN
      desc_bad = desc_bad ||
                 (|desc_q.src[$clog2(DATA_WIDTH/8)-1:0]) ||
                 (|desc_q.dst[$clog2(DATA_WIDTH/8)-1:0]) ||
                 (|rf_rd_data[$clog2(DATA_WIDTH/8)-1:0]);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:      if (poll_tc) next_state = ST_RD_CTRL;
         ST_RD_CTRL:   next_state = ST_CHK;
         ST_CHK:       next_state = ctrl_fire ? ST_FETCH : ST_IDLE;
         ST_FETCH:     if (fetch_cnt == 2'd3) next_state = desc_bad ? ST_IDLE : ST_ISSUE;
         ST_ISSUE:     if (desc_ready) next_state = ST_WAIT_DONE;
         ST_WAIT_DONE: if (eng_done) next_state = ST_DONE;
         ST_DONE:      next_state = ST_IDLE;
         default:      next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      rf_rd_en   = 1'b0;
      rf_rd_addr = '0;
      desc_valid = 1'b0;
      busy       = 1'b0;
      done_pulse = 1'b0;
      case (state)
         ST_RD_CTRL: begin
            rf_rd_en   = 1'b1;
            rf_rd_addr = ADDR_WIDTH'(REG_CTRL);
         end
         ST_FETCH: begin
            if (fetch_cnt != 2'd3) begin
               rf_rd_en   = 1'b1;
               rf_rd_addr = ADDR_WIDTH'(fetch_offset(fetch_cnt));
            end
         end
         ST_ISSUE: begin
            desc_valid = 1'b1;
            busy       = 1'b1;
         end
         ST_WAIT_DONE: busy       = 1'b1;
         ST_DONE:      done_pulse = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt  <= 2'd0;
         start_prev <= 1'b1;
         err_q      <= 1'b0;
         desc_q     <= '0;
      end else begin
         if (state == ST_CHK) begin
            start_prev <= rf_rd_data[CTRL_START_BIT];
            if (ctrl_fire) begin
               err_q <= 1'b0;
            end
         end
         if (state == ST_FETCH) begin
            fetch_cnt <= fetch_cnt + 2'd1;
            case (fetch_cnt)
               2'd1:    desc_q.src <= rf_rd_data;
               2'd2:    desc_q.dst <= rf_rd_data;
               2'd3:    desc_q.len <= rf_rd_data;
               default: ;
            endcase
            if ((fetch_cnt == 2'd3) && desc_bad) begin
               err_q <= 1'b1;
            end
         end else begin
            fetch_cnt <= 2'd0;
         end
      end
   end

   assign desc_src = desc_q.src;
   assign desc_dst = desc_q.dst;
   assign desc_len = desc_q.len;
   assign err      = err_q;

endmodule

// File: tb/tb_dma_desc_loader.sv
// tb/tb_dma_desc_loader.sv - scoreboard bench for dma_desc_loader
module tb_dma_desc_loader;

   import dma_desc_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        rf_rd_en;
   logic [7:0]  rf_rd_addr;
   logic [31:0] rf_rd_data = '0;
   logic        desc_valid;
   logic        desc_ready;
   logic [31:0] desc_src;
   logic [31:0] desc_dst;
   logic [31:0] desc_len;
   logic        eng_done;
   logic        busy;
   logic        done_pulse;
   logic        err;

   logic [31:0] regs [4];
   logic [7:0]  rd_log [$];
   desc_t       exp_q [$];

   int tests = 0;
   int fails = 0;
   int valid_cycles = 0;
   int done_seen = 0;
   int done_exp = 0;

   dma_desc_loader #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (8),
      .POLL_INTERVAL (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rf_rd_en   (rf_rd_en),
      .rf_rd_addr (rf_rd_addr),
      .rf_rd_data (rf_rd_data),
      .desc_valid (desc_valid),
      .desc_ready (desc_ready),
      .desc_src   (desc_src),
      .desc_dst   (desc_dst),
      .desc_len   (desc_len),
      .eng_done   (eng_done),
      .busy       (busy),
      .done_pulse (done_pulse),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Register file read port: one-cycle registered read.
   always @(posedge clk) begin
      if (rf_rd_en) begin
         rf_rd_data <= regs[rf_rd_addr[1:0]];
         rd_log.push_back(rf_rd_addr);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [31:0] prev_src, prev_dst, prev_len;

   // Scoreboard monitor: samples mid-cycle, pops an expectation at each handshake.
   always @(negedge clk) begin
      desc_t e;
      if (!reset) begin
         if (desc_valid) valid_cycles++;
         if (done_pulse) done_seen++;
         if (desc_valid && desc_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_desc: got src 0x%0h, expected no descriptor", desc_src);
            end else begin
               e = exp_q.pop_front();
               chk("sb_src", desc_src, e.src);
               chk("sb_dst", desc_dst, e.dst);
               chk("sb_len", desc_len, e.len);
            end
         end
         if (prev_valid && !prev_ready) begin
            chk("valid_held", desc_valid, 1);
            chk("src_stable", desc_src, prev_src);
            chk("dst_stable", desc_dst, prev_dst);
            chk("len_stable", desc_len, prev_len);
         end
         if (busy) chk("no_poll_while_busy", rf_rd_en, 0);
         prev_valid = desc_valid;
         prev_ready = desc_ready;
         prev_src   = desc_src;
         prev_dst   = desc_dst;
         prev_len   = desc_len;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ctrl_read(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!(rf_rd_en && rf_rd_addr == 8'h00) && n < 60);
      if (!(rf_rd_en && rf_rd_addr == 8'h00)) begin
         tests++;
         fails++;
         $display("FAIL ctrl_read_timeout: got no CTRL read in %0d cycles, expected one", n);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!desc_valid && n < 60);
      if (!desc_valid) begin
         tests++;
         fails++;
         $display("FAIL valid_timeout: got no desc_valid in %0d cycles, expected one", n);
      end
   endtask

   task automatic push_exp(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
      desc_t e;
      e.src = s;
      e.dst = d;
      e.len = l;
      exp_q.push_back(e);
   endtask

   // START seen 0 on one poll, then 1 on the next.
   task automatic start_pulse();
      int n;
      regs[0] = 32'h2;
      wait_ctrl_read(n);
      wait_ctrl_read(n);
      regs[0] = 32'h3;
   endtask

   // Entered in ISSUE with desc_ready high.
   task automatic xfer_done();
      step();
      chk("post_hs_valid", desc_valid, 0);
      chk("post_hs_busy", busy, 1);
      repeat (4) begin
         step();
         chk("wait_busy", busy, 1);
      end
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      chk("done_pulse", done_pulse, 1);
      chk("done_busy", busy, 0);
      done_exp++;
      step();
      chk("done_single", done_pulse, 0);
   endtask

   initial begin
      int n;
      int v0;
      logic [7:0] exp_rd [5] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03};

      reset      = 1'b1;
      desc_ready = 1'b1;
      eng_done   = 1'b0;
      regs[0] = 32'h2;
      regs[1] = 32'h100;
      regs[2] = 32'h200;
      regs[3] = 32'h40;
      repeat (3) step();
      chk("rst_rd_en", rf_rd_en, 0);
      chk("rst_valid", desc_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_pulse, 0);
      chk("rst_err", err, 0);
      chk("rst_src", desc_src, 0);

      // Basic descriptor and poll timing
      reset = 1'b0;
      rd_log.delete();
      wait_ctrl_read(n);
      chk("first_poll_latency", n, 4);
      wait_ctrl_read(n);
      chk("poll_period", n, 6);
      push_exp(32'h100, 32'h200, 32'h40);
      regs[0] = 32'h3;
      wait_valid(n);
      chk("ctrl_to_valid", n, 6);
      chk("t1_src", desc_src, 32'h100);
      chk("t1_dst", desc_dst, 32'h200);
      chk("t1_len", desc_len, 32'h40);
      chk("rd_log_size", rd_log.size(), 5);
      for (int i = 0; i < 5 && i < rd_log.size(); i++) chk("rd_addr_seq", rd_log[i], exp_rd[i]);
      xfer_done();

      // START held high: no retrigger
      v0 = valid_cycles;
      repeat (20) step();
      chk("no_retrigger", valid_cycles - v0, 0);

      // Stalled handshake, eng_done coincident with handshake is ignored
      desc_ready = 1'b0;
      push_exp(32'h100, 32'h200, 32'h40);
      start_pulse();
      wait_valid(n);
      for (int i = 0; i < 7; i++) begin
         chk("stall_valid", desc_valid, 1);
         chk("stall_src", desc_src, 32'h100);
         chk("stall_len", desc_len, 32'h40);
         step();
      end
      chk("stall_valid_c8", desc_valid, 1);
      desc_ready = 1'b1;
      eng_done   = 1'b1;
      step();
      eng_done = 1'b0;
      chk("early_done_valid", desc_valid, 0);
      chk("early_done_busy", busy, 1);
      chk("early_done_pulse", done_pulse, 0);
      repeat (2) step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      chk("stall_done_pulse", done_pulse, 1);
      done_exp++;
      step();

      // LEN == 0 rejected, err sticky until the next accepted start
      regs[3] = 32'h0;
      v0 = valid_cycles;
      start_pulse();
      repeat (7) step();
      chk("len0_err", err, 1);
      chk("len0_no_valid", valid_cycles - v0, 0);
      regs[3] = 32'h40;
      push_exp(32'h100, 32'h200, 32'h40);
      start_pulse();
      chk("err_sticky", err, 1);
      step();
      step();
      chk("err_cleared", err, 0);
      wait_valid(n);
      xfer_done();

      // Unaligned source
      regs[1] = 32'h102;
      v0 = valid_cycles;
`ifdef DMA_DESC_ALIGN_CHECK_EN
      start_pulse();
      repeat (7) step();
      chk("align_err", err, 1);
      chk("align_no_valid", valid_cycles - v0, 0);
`else
      push_exp(32'h102, 32'h200, 32'h40);
      start_pulse();
      wait_valid(n);
      chk("unaligned_src", desc_src, 32'h102);
      xfer_done();
`endif
      regs[1] = 32'h100;

      // Reset during WAIT_DONE with START held
      push_exp(32'h100, 32'h200, 32'h40);
      start_pulse();
      wait_valid(n);
      step();
      chk("pre_rst_busy", busy, 1);
      step();
      reset = 1'b1;
      #1;
      chk("async_busy", busy, 0);
      chk("async_valid", desc_valid, 0);
      chk("async_rd_en", rf_rd_en, 0);
      eng_done = 1'b1;
      step();
      step();
      eng_done = 1'b0;
      reset    = 1'b0;
      chk("post_rst_err", err, 0);
      v0 = valid_cycles;
      repeat (25) step();
      chk("held_start_no_fire", valid_cycles - v0, 0);
      push_exp(32'h100, 32'h200, 32'h40);
      start_pulse();
      wait_valid(n);
      xfer_done();

      repeat (3) step();
      chk("sb_queue_empty", exp_q.size(), 0);
      chk("done_count", done_seen, done_exp);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1);
   end

endmodule
